// File: rtl/nios2_vjtag_pkg.sv
// Shared definitions for the Nios II virtual-JTAG scan master: state encoding,
// virtual IR codes, default chain length and the per-state strobe decode.
// No ports; imported by the scan master and its TCK generator.
package nios2_vjtag_pkg;

   localparam int DR_WIDTH_DEFAULT = 38;

   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UIR  = 3'd1,
      CDR  = 3'd2,
      SDR  = 3'd3,
      UDR  = 3'd4
   } state_e;

   // One-hot virtual-state strobes presented to the target.
   typedef struct packed {
      logic rti;
      logic udr;
      logic sdr;
      logic cdr;
      logic uir;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '{rti: 1'b1, udr: 1'b0, sdr: 1'b0, cdr: 1'b0, uir: 1'b0};

   function automatic strobe_t strobe_of(input state_e st);
      strobe_t s;
      s = '0;
      case (st)
         UIR:     s.uir = 1'b1;
         CDR:     s.cdr = 1'b1;
         SDR:     s.sdr = 1'b1;
         UDR:     s.udr = 1'b1;
         default: s.rti = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/nios2_vjtag_tck_gen.sv
// Divided TCK generator: TCK_HALF clk cycles low then TCK_HALF high while enabled.
// Latency: first rise TCK_HALF cycles after enable; held low with counter cleared when disabled.
// Backpressure: none; rise_pulse/fall_pulse flag the clk edge on which tck toggles.
// Ports: clk, reset_n, enable in; tck, rise_pulse, fall_pulse out.
module nios2_vjtag_tck_gen
   import nios2_vjtag_pkg::*;
#(
   parameter int TCK_HALF = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic tck,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TCK_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          wrap;

   always_comb begin
      wrap  = enable && (cnt_q == CNT_LAST);
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!enable) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   // Pulses are asserted in the cycle whose closing edge moves tck, so the
   // consumer's flops update on the same edge as the pin.
   assign tck        = tck_q;
   assign rise_pulse = wrap & ~tck_q;
   assign fall_pulse = wrap &  tck_q;

endmodule

// File: rtl/nios2_vjtag_scan_master.sv
// Host-side virtual-JTAG scan initiator: UIR, CDR, SDR x DR_WIDTH, UDR with divided TCK, TDO captured.
// Latency: accept at cycle 0 -> rsp_valid at cycle 1 + (DR_WIDTH+3)*2*TCK_HALF.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored, never queued.
// Ports: cmd_valid/cmd_ready/cmd_ir/cmd_dr in, rsp_valid/rsp_dr/busy out; vj_tck, vj_tdi,
//        vj_ir_in and the vj_uir/cdr/sdr/udr/rti strobes drive the target, vj_tdo returns data.
module nios2_vjtag_scan_master
   import nios2_vjtag_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
   parameter int IR_WIDTH = 2,
   parameter int TCK_HALF = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                busy,
   output logic                vj_tck,
   output logic                vj_tdi,
   input  logic                vj_tdo,
   output logic [IR_WIDTH-1:0] vj_ir_in,
   output logic                vj_uir,
   output logic                vj_cdr,
   output logic                vj_sdr,
   output logic                vj_udr,
   output logic                vj_rti
);

   localparam int BW = $clog2(DR_WIDTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

   state_e              state_q, state_d;
   strobe_t             strb_q, strb_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                tdi_q, tdi_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                tck_en, tck, tck_rise, tck_fall;

   assign tck_en = (state_q != IDLE);

   nios2_vjtag_tck_gen #(
      .TCK_HALF (TCK_HALF)
   ) u_tck_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (tck_en),
      .tck        (tck),
      .rise_pulse (tck_rise),
      .fall_pulse (tck_fall)
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cap_d       = cap_q;
      rsp_dr_d    = rsp_dr_q;
      bit_d       = bit_q;
      ir_d        = ir_q;
      tdi_d       = tdi_q;
      rsp_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = UIR;
               ir_d    = cmd_ir;
               sr_d    = cmd_dr;
            end
         end
         UIR: begin
            if (tck_fall) state_d = CDR;
         end
         CDR: begin
            // Target tdo is already valid after the CDR rise, so the first
            // SDR rise captures bit 0 with no extra shift.
            if (tck_fall) begin
               state_d = SDR;
               bit_d   = '0;
               tdi_d   = sr_q[0];
            end
         end
         SDR: begin
            if (tck_rise) cap_d = {vj_tdo, cap_q[DR_WIDTH-1:1]};
            if (tck_fall) begin
               sr_d = sr_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = UDR;
                  tdi_d   = 1'b0;
               end else begin
                  bit_d = bit_q + BW'(1);
                  tdi_d = sr_q[1];
               end
            end
         end
         UDR: begin
            if (tck_fall) begin
               state_d     = IDLE;
               rsp_dr_d    = cap_q;
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      strb_d = strobe_of(state_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         strb_q      <= STROBE_IDLE;
         sr_q        <= '0;
         cap_q       <= '0;
         rsp_dr_q    <= '0;
         bit_q       <= '0;
         ir_q        <= '0;
         tdi_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         strb_q      <= strb_d;
         sr_q        <= sr_d;
         cap_q       <= cap_d;
         rsp_dr_q    <= rsp_dr_d;
         bit_q       <= bit_d;
         ir_q        <= ir_d;
         tdi_q       <= tdi_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = ~cmd_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dr    = rsp_dr_q;
   assign vj_tck    = tck;
   assign vj_tdi    = tdi_q;
   assign vj_ir_in  = ir_q;
   assign vj_uir    = strb_q.uir;
   assign vj_cdr    = strb_q.cdr;
   assign vj_sdr    = strb_q.sdr;
   assign vj_udr    = strb_q.udr;
   assign vj_rti    = strb_q.rti;

endmodule

// File: tb/tb_nios2_vjtag_scan_master.sv
// Bench for nios2_vjtag_scan_master: random commands against a target shift-register model,
// expectations queued at issue and checked by an independent monitor on rsp_valid.
// A second, minimal instance (DR_WIDTH=4, TCK_HALF=1) runs with tdo looped back to tdi.
module tb_nios2_vjtag_scan_master;
   import nios2_vjtag_pkg::*;

   localparam int DR    = 38;
   localparam int H     = 2;
   localparam int LAT   = 1 + (DR + 3) * 2 * H;
   localparam int DR_S  = 4;
   localparam int LAT_S = 1 + (DR_S + 3) * 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          cmd_valid, cmd_ready, rsp_valid, busy;
   logic [1:0]    cmd_ir, vj_ir_in;
   logic [DR-1:0] cmd_dr, rsp_dr;
   logic          vj_tck, vj_tdi, vj_tdo, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;

   logic            cmd_valid_s, cmd_ready_s, rsp_valid_s, busy_s;
   logic [1:0]      cmd_ir_s, vj_ir_in_s;
   logic [DR_S-1:0] cmd_dr_s, rsp_dr_s;
   logic            vj_tck_s, vj_tdi_s, vj_tdo_s, vj_uir_s, vj_cdr_s, vj_sdr_s, vj_udr_s, vj_rti_s;

   nios2_vjtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(2), .TCK_HALF(H)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .busy(busy),
      .vj_tck(vj_tck), .vj_tdi(vj_tdi), .vj_tdo(vj_tdo), .vj_ir_in(vj_ir_in),
      .vj_uir(vj_uir), .vj_cdr(vj_cdr), .vj_sdr(vj_sdr), .vj_udr(vj_udr), .vj_rti(vj_rti));

   nios2_vjtag_scan_master #(.DR_WIDTH(DR_S), .IR_WIDTH(2), .TCK_HALF(1)) dut_s (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
      .cmd_ir(cmd_ir_s), .cmd_dr(cmd_dr_s), .rsp_valid(rsp_valid_s), .rsp_dr(rsp_dr_s), .busy(busy_s),
      .vj_tck(vj_tck_s), .vj_tdi(vj_tdi_s), .vj_tdo(vj_tdo_s), .vj_ir_in(vj_ir_in_s),
      .vj_uir(vj_uir_s), .vj_cdr(vj_cdr_s), .vj_sdr(vj_sdr_s), .vj_udr(vj_udr_s), .vj_rti(vj_rti_s));

   assign vj_tdo_s = vj_tdi_s;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Target data register: loads its capture value at the CDR rise, samples
   // tdi on each SDR rise and shifts it in on the following fall.
   logic [DR-1:0] tgt_q;
   logic [DR-1:0] tgt_pre   = '0;
   logic          tgt_armed = 1'b0;
   logic          tgt_tdi_s = 1'b0;
   assign vj_tdo = tgt_q[0];

   always @(posedge vj_tck) begin
      if (vj_cdr) tgt_q = tgt_pre;
      tgt_armed = vj_sdr;
      tgt_tdi_s = vj_tdi;
   end
   always @(negedge vj_tck) begin
      if (tgt_armed) begin
         tgt_q     = {tgt_tdi_s, tgt_q[DR-1:1]};
         tgt_armed = 1'b0;
      end
   end

   typedef struct {
      logic [1:0]    ir;
      logic [DR-1:0] rsp;
      logic [DR-1:0] dr;
      int            acc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int            n_uir, n_cdr, n_sdr, n_udr, viol, rdy_low;
   logic [1:0]    ir_seen;
   logic          prev_tck, prev_tdi;
   logic [DR-1:0] done_pre = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; viol = 0; rdy_low = 0;
         prev_tck = 1'b0; prev_tdi = 1'b0; ir_seen = 2'b00;
      end else begin
         if ($countones({vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}) != 1) viol++;
         if (cmd_ready == busy) viol++;
         if (vj_rti && vj_tck) viol++;
         if ((vj_tdi != prev_tdi) && !(prev_tck && !vj_tck)) viol++;
         if (!prev_tck && vj_tck) begin
            if (vj_uir) begin n_uir++; ir_seen = vj_ir_in; end
            if (vj_cdr) n_cdr++;
            if (vj_sdr) n_sdr++;
            if (vj_udr) n_udr++;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_rsp: rsp_valid=1 rsp_dr=0x%0h, want no response", rsp_dr);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_dr", 64'(rsp_dr), 64'(mon_e.rsp));
               check("latency", 64'(cyc - mon_e.acc), 64'(LAT));
               check("target_shifted_in", 64'(tgt_q), 64'(mon_e.dr));
               check("ir_during_uir", 64'(ir_seen), 64'(mon_e.ir));
               check("ir_held", 64'(vj_ir_in), 64'(mon_e.ir));
               check("uir_periods", 64'(n_uir), 64'(1));
               check("cdr_periods", 64'(n_cdr), 64'(1));
               check("sdr_periods", 64'(n_sdr), 64'(DR));
               check("udr_periods", 64'(n_udr), 64'(1));
               check("strobe_tdi_violations", 64'(viol), 64'(0));
               check("ready_low_cycles", 64'(rdy_low), 64'(LAT - 1));
               done_pre = mon_e.rsp;
            end
            n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; viol = 0;
         end
         if (!cmd_ready) rdy_low++;
         else rdy_low = 0;
         prev_tck = vj_tck;
         prev_tdi = vj_tdi;
      end
   end

   // Small instance: tdi sequence in time order and loopback response.
   logic exp_tdi_s [DR_S] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic tdi_seq_s[$];
   logic prev_tck_s = 1'b0;
   logic small_done = 1'b0;
   int   acc_s      = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_tck_s = 1'b0;
         tdi_seq_s.delete();
      end else begin
         if (!prev_tck_s && vj_tck_s && vj_sdr_s) tdi_seq_s.push_back(vj_tdi_s);
         prev_tck_s = vj_tck_s;
         if (rsp_valid_s) begin
            check("small_latency", 64'(cyc - acc_s), 64'(LAT_S));
            check("small_rsp_loopback", 64'(rsp_dr_s), 64'(4'b1001));
            check("small_tdi_count", 64'(tdi_seq_s.size()), 64'(DR_S));
            for (int i = 0; i < DR_S && i < tdi_seq_s.size(); i++)
               check($sformatf("small_tdi_%0d", i), 64'(tdi_seq_s[i]), 64'(exp_tdi_s[i]));
            small_done = 1'b1;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   int last_acc = 0;

   task automatic send(input logic [1:0] ir, input logic [DR-1:0] dr, input logic [DR-1:0] pre);
      int   n = 0;
      exp_t e;
      tick();
      cmd_valid = 1'b1;
      cmd_ir    = ir;
      cmd_dr    = dr;
      while (!cmd_ready && n < 1000) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, want 1", n);
      end else begin
         tgt_pre  = pre;
         e.ir     = ir;
         e.rsp    = pre;
         e.dr     = dr;
         e.acc    = cyc;
         last_acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic drop();
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [DR-1:0] rnd();
      return DR'({$urandom(), $urandom()});
   endfunction

   localparam logic [12:0] RESET_OUTS = 13'b0_0_00_0_0_0_0_1_1_0_0;

   initial begin
      logic [DR-1:0] d;
      logic [1:0]    ir;
      int            a1, a2, n;

      reset_n = 1'b1;
      cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = '0;
      cmd_valid_s = 1'b0; cmd_ir_s = 2'b00; cmd_dr_s = '0;
      #1 reset_n = 1'b0;
      #1;
      check("reset_outs", 64'({vj_tck, vj_tdi, vj_ir_in, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti,
                               cmd_ready, busy, rsp_valid}), 64'(RESET_OUTS));
      check("reset_rsp_dr", 64'(rsp_dr), 64'(0));
      check("reset_outs_small", 64'({vj_tck_s, vj_tdi_s, vj_ir_in_s, vj_uir_s, vj_cdr_s, vj_sdr_s,
                                     vj_udr_s, vj_rti_s, cmd_ready_s, busy_s, rsp_valid_s}), 64'(RESET_OUTS));
      check("reset_rsp_dr_small", 64'(rsp_dr_s), 64'(0));
      repeat (3) tick();
      reset_n = 1'b1;

      // DR_WIDTH=4, TCK_HALF=1: LSB-first tdi and 15-cycle latency.
      tick();
      check("small_ready", 64'(cmd_ready_s), 64'(1));
      cmd_valid_s = 1'b1;
      cmd_ir_s    = IR_BREAK;
      cmd_dr_s    = 4'b1001;
      acc_s       = cyc;
      tick();
      cmd_valid_s = 1'b0;
      n = 0;
      while (!small_done && n < 200) begin tick(); n++; end
      if (!small_done) begin
         total++; bad++;
         $display("FAIL small_timeout: rsp_valid_s never seen, want pulse at +%0d", LAT_S);
      end

      // Loopback with the fixed patterns.
      send(IR_TRACEMEM, 38'h15_0F0F_0F0F, 38'h2A_5A5A_5A5A);
      drop();
      wait_drain();

      send(IR_BREAK, rnd(), rnd());
      drop();
      wait_drain();

      // Back-to-back with cmd_valid held: second accept lands in the rsp_valid cycle.
      send(2'($urandom_range(0, 3)), rnd(), rnd());
      a1 = last_acc;
      send(2'($urandom_range(0, 3)), rnd(), rnd());
      a2 = last_acc;
      drop();
      check("b2b_accept_gap", 64'(a2 - a1), 64'(LAT));
      wait_drain();

      // Commands offered while busy must not disturb the scan in flight.
      ir = IR_OCIMEM;
      d  = rnd();
      send(ir, d, rnd());
      repeat (40) begin
         tick();
         cmd_valid = 1'b1;
         cmd_ir    = ~ir;
         cmd_dr    = ~d;
      end
      check("busy_ir_hold", 64'(vj_ir_in), 64'(ir));
      check("busy_rsp_hold", 64'(rsp_dr), 64'(done_pre));
      cmd_valid = 1'b0;
      wait_drain();

      for (int k = 0; k < 8; k++) begin
         send(2'($urandom_range(0, 3)), rnd(), rnd());
         drop();
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_drain();

      // Reset mid-scan: everything clears at once and no response follows.
      send(IR_TRACECTRL, rnd(), rnd());
      drop();
      n = 0;
      while (n_sdr < 20 && n < 1000) begin tick(); n++; end
      check("reached_sdr_bit20", 64'(n_sdr), 64'(20));
      reset_n = 1'b0;
      #1;
      check("midscan_reset_outs", 64'({vj_tck, vj_tdi, vj_ir_in, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti,
                                       cmd_ready, busy, rsp_valid}), 64'(RESET_OUTS));
      check("midscan_reset_rsp_dr", 64'(rsp_dr), 64'(0));
      sb.delete();
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (200) tick();

      send(IR_OCIMEM, rnd(), rnd());
      drop();
      wait_drain();
      repeat (5) tick();
      check("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
